// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and status counter width.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        STAGE     = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_ff.sv
// Async-reset flop chain for bringing a level signal into the local clock domain.
// Latency STAGES edges; no backpressure.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: filters PLL lock, holds resets, then releases domains in order.
// Release of rst_out[0] lands SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES+1 edges after lock; no backpressure.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_OUT       = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int LOCK_FILTER = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic                  lock,
    input  logic                  sw_rst,
    output logic [N_OUT-1:0]      rst_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            state
);

    localparam int FW = $clog2(LOCK_FILTER) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;

    localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    logic                  w_lock_s;
    logic [N_OUT-1:0]      w_shift;
    logic [FW-1:0]         r_filt;
    logic [HW-1:0]         r_hold;
    logic [GW-1:0]         r_gap;
    state_t                r_state;
    logic [N_OUT-1:0]      r_rst_out;
    logic                  r_ready;
    logic [LOSS_CNT_W-1:0] r_loss;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk (clk25),
        .i_rst (rst),
        .i_d   (lock),
        .o_q   (w_lock_s)
    );

    // Shifting a zero in from the bottom keeps rst_out thermometer-coded.
    assign w_shift = r_rst_out << 1;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_filt <= '0;
        end else if (!w_lock_s) begin
            r_filt <= '0;
        end else if (r_filt != FILT_MAX) begin
            r_filt <= r_filt + 1'b1;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state   <= WAIT_LOCK;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_loss    <= '0;
            r_hold    <= '0;
            r_gap     <= '0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (r_filt == FILT_MAX) begin
                        r_state <= HOLD;
                        r_hold  <= '0;
                    end
                end
                HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (sw_rst) begin
                        r_hold <= '0;
                    end else if (r_hold == HOLD_LAST) begin
                        r_rst_out <= w_shift;
                        r_gap     <= '0;
                        if (w_shift == '0) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= STAGE;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                STAGE, RUN: begin
                    // Lock loss outranks a simultaneous software request.
                    if (!w_lock_s) begin
                        r_state   <= WAIT_LOCK;
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
                        if (r_loss != '1) begin
                            r_loss <= r_loss + 1'b1;
                        end
                    end else if (sw_rst) begin
                        r_state   <= HOLD;
                        r_hold    <= '0;
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
                    end else if (r_state == STAGE) begin
                        if (r_gap == GAP_LAST) begin
                            r_gap     <= '0;
                            r_rst_out <= w_shift;
                            if (w_shift == '0) begin
                                r_state <= RUN;
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end
                default: r_state <= WAIT_LOCK;
            endcase
        end
    end

    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_loss;
    assign state         = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edge numbers count from the
// first clk25 edge after lock rises, outputs are sampled 1 time unit after each edge.
module tb_reset_sequencer;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       lock;
    logic       sw_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;
    int e     = 0;

    always #5 clk25 = ~clk25;

    reset_sequencer #(
        .N_OUT       (3),
        .HOLD_CYCLES (16),
        .STAGE_GAP   (8),
        .LOCK_FILTER (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk25         (clk25),
        .rst           (rst),
        .lock          (lock),
        .sw_rst        (sw_rst),
        .rst_out       (rst_out),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state)
    );

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic adv_to(input int target);
        while (e < target) begin
            tick();
            e++;
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_rst,
                       input logic exp_rdy, input logic [1:0] exp_st);
        n_vec++;
        assert ({rst_out, ready, state} === {exp_rst, exp_rdy, exp_st})
        else begin
            n_err++;
            $error("FAIL %s @edge %0d: rst_out/ready/state observed %b/%b/%0d expected %b/%b/%0d",
                   tag, e, rst_out, ready, state, exp_rst, exp_rdy, exp_st);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] exp_cnt);
        n_vec++;
        assert (lock_loss_cnt === exp_cnt)
        else begin
            n_err++;
            $error("FAIL %s: lock_loss_cnt observed %0d expected %0d", tag, lock_loss_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst = 1'b0; lock = 1'b0; sw_rst = 1'b0;

        // Async reset takes effect with no clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 3'b111, 1'b0, 2'd0);
        chk_cnt("rst_async_cnt", 8'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_release", 3'b111, 1'b0, 2'd0);

        // sw_rst is ignored while waiting for lock
        sw_rst = 1'b1; tick(); sw_rst = 1'b0; tick();
        chk("swrst_in_wait", 3'b111, 1'b0, 2'd0);

        // One-cycle lock glitch sampled at edge 3 restarts the filter: release moves 22 -> 26
        lock = 1'b1; e = -1;
        adv_to(2); lock = 1'b0;
        adv_to(3); lock = 1'b1;
        adv_to(9);  chk("gl_still_wait", 3'b111, 1'b0, 2'd0);
        adv_to(10); chk("gl_hold",       3'b111, 1'b0, 2'd1);
        adv_to(25); chk("gl_pre_rel0",   3'b111, 1'b0, 2'd1);
        adv_to(26); chk("gl_rel0",       3'b110, 1'b0, 2'd2);
        adv_to(34); chk("gl_rel1",       3'b100, 1'b0, 2'd2);
        adv_to(42); chk("gl_rel2",       3'b000, 1'b1, 2'd3);
        chk_cnt("gl_cnt", 8'd0);

        // Clean power-up: 22 / 30 / 38
        rst = 1'b1; lock = 1'b0; tick(); rst = 1'b0; tick(); tick();
        lock = 1'b1; e = -1;
        adv_to(5);  chk("pu_wait",     3'b111, 1'b0, 2'd0);
        adv_to(6);  chk("pu_hold",     3'b111, 1'b0, 2'd1);
        adv_to(21); chk("pu_pre_rel0", 3'b111, 1'b0, 2'd1);
        adv_to(22); chk("pu_rel0",     3'b110, 1'b0, 2'd2);
        adv_to(29); chk("pu_pre_rel1", 3'b110, 1'b0, 2'd2);
        adv_to(30); chk("pu_rel1",     3'b100, 1'b0, 2'd2);
        adv_to(37); chk("pu_pre_rel2", 3'b100, 1'b0, 2'd2);
        adv_to(38); chk("pu_rel2",     3'b000, 1'b1, 2'd3);

        // Lock drops in RUN: sampled low at 39, synchronised low at 41
        lock = 1'b0;
        adv_to(40); chk("ll_pre_abort", 3'b000, 1'b1, 2'd3);
        adv_to(41); chk("ll_abort",     3'b111, 1'b0, 2'd0);
        chk_cnt("ll_cnt", 8'd1);
        adv_to(44);
        lock = 1'b1; e = -1;
        adv_to(21); chk("rl_pre_rel0", 3'b111, 1'b0, 2'd1);
        adv_to(22); chk("rl_rel0",     3'b110, 1'b0, 2'd2);
        adv_to(30); chk("rl_rel1",     3'b100, 1'b0, 2'd2);
        adv_to(38); chk("rl_rel2",     3'b000, 1'b1, 2'd3);

        // sw_rst in RUN: back to HOLD, releases 16 / +8 / +8 edges later
        sw_rst = 1'b1; adv_to(39); sw_rst = 1'b0;
        chk("sw_abort", 3'b111, 1'b0, 2'd1);
        adv_to(54); chk("sw_pre_rel0", 3'b111, 1'b0, 2'd1);
        adv_to(55); chk("sw_rel0",     3'b110, 1'b0, 2'd2);
        adv_to(63); chk("sw_rel1",     3'b100, 1'b0, 2'd2);
        adv_to(71); chk("sw_rel2",     3'b000, 1'b1, 2'd3);
        chk_cnt("sw_cnt", 8'd1);

        // sw_rst and synchronised lock loss on the same STAGE edge: lock loss wins
        sw_rst = 1'b1; adv_to(72); sw_rst = 1'b0;
        chk("co_hold", 3'b111, 1'b0, 2'd1);
        adv_to(88); chk("co_stage", 3'b110, 1'b0, 2'd2);
        adv_to(89); lock = 1'b0;
        adv_to(91); chk("co_pre", 3'b110, 1'b0, 2'd2);
        sw_rst = 1'b1; adv_to(92); sw_rst = 1'b0;
        chk("co_abort", 3'b111, 1'b0, 2'd0);
        chk_cnt("co_cnt", 8'd2);

        // rst mid-STAGE at edge 33 clears everything without a clock edge
        lock = 1'b1; e = -1;
        adv_to(33); chk("mr_stage", 3'b100, 1'b0, 2'd2);
        #2 rst = 1'b1;
        #1;
        chk("mr_async", 3'b111, 1'b0, 2'd0);
        chk_cnt("mr_cnt", 8'd0);
        lock = 1'b0;
        tick(); rst = 1'b0; tick(); tick();

        // 256 lock losses from STAGE: counter saturates at 255
        for (int i = 0; i < 256; i++) begin
            int t;
            lock = 1'b1;
            t = 0;
            while (state !== 2'd2 && t < 100) begin tick(); t++; end
            chk("sat_reach_stage", 3'b110, 1'b0, 2'd2);
            lock = 1'b0;
            t = 0;
            while (state !== 2'd0 && t < 10) begin tick(); t++; end
            chk("sat_abort", 3'b111, 1'b0, 2'd0);
            tick(); tick();
            if (i == 253) chk_cnt("sat_254", 8'd254);
        end
        chk_cnt("sat_255", 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
